// File: rtl/cursor_move_arbiter.sv
// rtl/cursor_move_arbiter.sv - two-cursor tile move arbiter with boundary, collision and cooldown checks
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   a_req, a_dir             cursor A level move request and direction
//   b_req, b_dir             cursor B level move request and direction
//                            dir: 00 left, 01 right, 10 up, 11 down
//   a_ack, a_nack            one-cycle response pulses for A
//   b_ack, b_nack            one-cycle response pulses for B
//   a_ready, b_ready         cooldown expired for A / B
//   a_h, a_v, b_h, b_v       registered cursor positions (column, row)

module cursor_move_arbiter #(
    parameter int HMAX     = 9,
    parameter int VMAX     = 5,
    parameter int CD_W     = 26,
    parameter int COOLDOWN = 2**25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic [1:0] a_dir,
    input  logic       b_req,
    input  logic [1:0] b_dir,
    output logic       a_ack,
    output logic       a_nack,
    output logic       b_ack,
    output logic       b_nack,
    output logic       a_ready,
    output logic       b_ready,
    output logic [3:0] a_h,
    output logic [3:0] a_v,
    output logic [3:0] b_h,
    output logic [3:0] b_v
);

    localparam logic [3:0]      H_LIM  = 4'(HMAX);
    localparam logic [3:0]      V_LIM  = 4'(VMAX);
    localparam logic [CD_W-1:0] CD_LIM = CD_W'(COOLDOWN);

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    // Round-robin pointer: which cursor wins a tie
    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t prio;
    prio_t prio_next;

    logic [CD_W-1:0] cnt_a;
    logic [CD_W-1:0] cnt_b;

    logic a_elig;
    logic b_elig;
    logic grant_a;
    logic grant_b;

    logic [3:0] cur_h;
    logic [3:0] cur_v;
    logic [3:0] oth_h;
    logic [3:0] oth_v;
    logic [1:0] dir;
    logic [3:0] tgt_h;
    logic [3:0] tgt_v;
    logic       off_grid;
    logic       collide;
    logic       accept;

    assign a_ready = (cnt_a == CD_LIM);
    assign b_ready = (cnt_b == CD_LIM);

    // A response pulse in flight excludes that cursor, so a held request
    // is not granted twice for the same transaction.
    assign a_elig = a_req && a_ready && !a_ack && !a_nack;
    assign b_elig = b_req && b_ready && !b_ack && !b_nack;

    assign grant_a = a_elig && (!b_elig || (prio == PRIO_A));
    assign grant_b = b_elig && (!a_elig || (prio == PRIO_B));

    // Only one cursor is granted per cycle, so a single checker serves both.
    always_comb begin
        cur_h = a_h;
        cur_v = a_v;
        oth_h = b_h;
        oth_v = b_v;
        dir   = a_dir;
        if (grant_b) begin
            cur_h = b_h;
            cur_v = b_v;
            oth_h = a_h;
            oth_v = a_v;
            dir   = b_dir;
        end
    end

    // Boundary test is done before any arithmetic so no 4-bit wrap occurs.
    always_comb begin
        tgt_h    = cur_h;
        tgt_v    = cur_v;
        off_grid = 1'b0;
        case (dir)
            DIR_LEFT: begin
                if (cur_h == 4'd0) off_grid = 1'b1;
                else               tgt_h = cur_h - 4'd1;
            end
            DIR_RIGHT: begin
                if (cur_h >= H_LIM) off_grid = 1'b1;
                else                tgt_h = cur_h + 4'd1;
            end
            DIR_UP: begin
                if (cur_v == 4'd0) off_grid = 1'b1;
                else               tgt_v = cur_v - 4'd1;
            end
            DIR_DOWN: begin
                if (cur_v >= V_LIM) off_grid = 1'b1;
                else                tgt_v = cur_v + 4'd1;
            end
            default: off_grid = 1'b1;
        endcase
    end

    assign collide = (tgt_h == oth_h) && (tgt_v == oth_v);
    assign accept  = !off_grid && !collide;

    // After any grant the other cursor becomes favoured.
    always_comb begin
        prio_next = prio;
        if (grant_a)      prio_next = PRIO_B;
        else if (grant_b) prio_next = PRIO_A;
    end

    always_ff @(posedge clk) begin
        if (rst) prio <= PRIO_A;
        else     prio <= prio_next;
    end

    // Response pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            a_ack  <= 1'b0;
            a_nack <= 1'b0;
            b_ack  <= 1'b0;
            b_nack <= 1'b0;
        end else begin
            a_ack  <= grant_a && accept;
            a_nack <= grant_a && !accept;
            b_ack  <= grant_b && accept;
            b_nack <= grant_b && !accept;
        end
    end

    // Cursor A position and cooldown
    always_ff @(posedge clk) begin
        if (rst) begin
            a_h   <= 4'd0;
            a_v   <= 4'd0;
            cnt_a <= CD_LIM;
        end else if (grant_a && accept) begin
            a_h   <= tgt_h;
            a_v   <= tgt_v;
            cnt_a <= '0;
        end else if (cnt_a != CD_LIM) begin
            cnt_a <= cnt_a + 1'b1;
        end
    end

    // Cursor B position and cooldown
    always_ff @(posedge clk) begin
        if (rst) begin
            b_h   <= H_LIM;
            b_v   <= V_LIM;
            cnt_b <= CD_LIM;
        end else if (grant_b && accept) begin
            b_h   <= tgt_h;
            b_v   <= tgt_v;
            cnt_b <= '0;
        end else if (cnt_b != CD_LIM) begin
            cnt_b <= cnt_b + 1'b1;
        end
    end

endmodule

// File: tb/tb_cursor_move_arbiter.sv
// tb/tb_cursor_move_arbiter.sv - self-checking bench for cursor_move_arbiter

module tb_cursor_move_arbiter;

    localparam int HMAX     = 9;
    localparam int VMAX     = 5;
    localparam int CD_W     = 26;
    localparam int COOLDOWN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_req = 1'b0;
    logic [1:0] a_dir = 2'b00;
    logic       b_req = 1'b0;
    logic [1:0] b_dir = 2'b00;
    logic       a_ack, a_nack, b_ack, b_nack;
    logic       a_ready, b_ready;
    logic [3:0] a_h, a_v, b_h, b_v;

    int n_tests = 0;
    int n_fail  = 0;

    cursor_move_arbiter #(
        .HMAX(HMAX), .VMAX(VMAX), .CD_W(CD_W), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_dir(a_dir), .b_req(b_req), .b_dir(b_dir),
        .a_ack(a_ack), .a_nack(a_nack), .b_ack(b_ack), .b_nack(b_nack),
        .a_ready(a_ready), .b_ready(b_ready),
        .a_h(a_h), .a_v(a_v), .b_h(b_h), .b_v(b_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks positions, the cycle each ack became visible (ready is a pure
    // function of elapsed cycles), the response visible this cycle and the
    // tie-break owner.
    int m_h[2], m_v[2], m_ackc[2], m_resp[2];
    int m_prio;
    int cyc = 0;
    bit m_valid = 1'b0;
    int mr[2], md[2], g, nh, nv;
    bit el[2], ok;

    function automatic bit m_ready(input int x);
        return cyc >= m_ackc[x] + COOLDOWN;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_a_h", a_h, m_h[0]);
            chk("cmp_a_v", a_v, m_v[0]);
            chk("cmp_b_h", b_h, m_h[1]);
            chk("cmp_b_v", b_v, m_v[1]);
            chk("cmp_a_ack", a_ack, m_resp[0] == 1);
            chk("cmp_a_nack", a_nack, m_resp[0] == 2);
            chk("cmp_b_ack", b_ack, m_resp[1] == 1);
            chk("cmp_b_nack", b_nack, m_resp[1] == 2);
            chk("cmp_a_ready", a_ready, m_ready(0));
            chk("cmp_b_ready", b_ready, m_ready(1));
        end
        if (rst) begin
            m_h[0] = 0;    m_v[0] = 0;
            m_h[1] = HMAX; m_v[1] = VMAX;
            m_ackc[0] = -1000; m_ackc[1] = -1000;
            m_resp[0] = 0; m_resp[1] = 0;
            m_prio = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            mr[0] = int'(a_req); mr[1] = int'(b_req);
            md[0] = int'(a_dir); md[1] = int'(b_dir);
            for (int x = 0; x < 2; x++)
                el[x] = (mr[x] == 1) && m_ready(x) && (m_resp[x] == 0);
            if (el[0] && el[1]) g = m_prio;
            else if (el[0])     g = 0;
            else if (el[1])     g = 1;
            else                g = -1;
            m_resp[0] = 0; m_resp[1] = 0;
            if (g >= 0) begin
                nh = m_h[g] + (md[g] == 1 ? 1 : 0) - (md[g] == 0 ? 1 : 0);
                nv = m_v[g] + (md[g] == 3 ? 1 : 0) - (md[g] == 2 ? 1 : 0);
                ok = (nh >= 0) && (nh <= HMAX) && (nv >= 0) && (nv <= VMAX)
                     && !((nh == m_h[1-g]) && (nv == m_v[1-g]));
                if (ok) begin
                    m_h[g] = nh; m_v[g] = nv;
                    m_ackc[g] = cyc + 1;
                    m_resp[g] = 1;
                end else begin
                    m_resp[g] = 2;
                end
                m_prio = 1 - g;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // exp: 1 ack, 2 nack
    task automatic move_a(input logic [1:0] d, input int exp);
        int got;
        got = 0;
        a_req = 1'b1;
        a_dir = d;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (a_ack || a_nack) begin
                got = a_ack ? 1 : 2;
                break;
            end
        end
        a_req = 1'b0;
        chk("move_a_resp", got, exp);
        for (int i = 0; i < 20; i++) begin
            if (a_ready) break;
            step(1);
        end
        chk("move_a_ready", a_ready, 1);
    endtask

    initial begin
        // reset
        step(2);
        chk("rst_a_h", a_h, 0);
        chk("rst_a_v", a_v, 0);
        chk("rst_b_h", b_h, 9);
        chk("rst_b_v", b_v, 5);
        chk("rst_ready", {a_ready, b_ready}, 2'b11);
        chk("rst_pulses", {a_ack, a_nack, b_ack, b_nack}, 4'b0000);
        rst = 1'b0;

        // single move with held request
        a_req = 1'b1; a_dir = 2'b01;
        step(1);
        chk("single_ack", a_ack, 1);
        chk("single_h", a_h, 1);
        chk("single_ready_t1", a_ready, 0);
        step(3);
        chk("single_ready_t4", a_ready, 0);
        step(1);
        chk("single_ready_t5", a_ready, 1);
        chk("single_h_t5", a_h, 1);
        step(1);
        chk("held_ack", a_ack, 1);
        chk("held_h", a_h, 2);
        a_req = 1'b0;

        // boundary
        rst = 1'b1; step(1); rst = 1'b0;
        a_req = 1'b1; a_dir = 2'b00;
        step(1);
        chk("bnd_a_nack", a_nack, 1);
        chk("bnd_a_h", a_h, 0);
        chk("bnd_a_ready", a_ready, 1);
        a_req = 1'b0;
        b_req = 1'b1; b_dir = 2'b11;
        step(1);
        chk("bnd_b_nack", b_nack, 1);
        chk("bnd_b_v", b_v, 5);
        b_req = 1'b0;

        // simultaneous
        rst = 1'b1; step(1); rst = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_dir = 2'b01; b_dir = 2'b00;
        step(1);
        chk("sim_a_ack", a_ack, 1);
        chk("sim_a_h", a_h, 1);
        chk("sim_b_idle", b_ack, 0);
        a_req = 1'b0;
        step(1);
        chk("sim_b_ack", b_ack, 1);
        chk("sim_b_h", b_h, 8);
        b_req = 1'b0;
        step(4);
        chk("sim_both_ready", {a_ready, b_ready}, 2'b11);
        // an A-only grant (nack off the top edge) hands the tie-break to B
        a_req = 1'b1; a_dir = 2'b10;
        step(1);
        chk("sim_a_up_nack", a_nack, 1);
        a_req = 1'b0;
        step(1);
        a_req = 1'b1; b_req = 1'b1; a_dir = 2'b01; b_dir = 2'b00;
        step(1);
        chk("sim2_b_first", b_ack, 1);
        chk("sim2_b_h", b_h, 7);
        chk("sim2_a_wait", a_ack, 0);
        b_req = 1'b0;
        step(1);
        chk("sim2_a_ack", a_ack, 1);
        chk("sim2_a_h", a_h, 2);
        a_req = 1'b0;

        // collision
        rst = 1'b1; step(1); rst = 1'b0;
        for (int i = 0; i < 8; i++) move_a(2'b01, 1);
        for (int i = 0; i < 5; i++) move_a(2'b11, 1);
        chk("col_a_h", a_h, 8);
        chk("col_a_v", a_v, 5);
        move_a(2'b01, 2);
        chk("col_a_h_kept", a_h, 8);
        b_req = 1'b1; b_dir = 2'b00;
        step(1);
        chk("col_b_nack", b_nack, 1);
        chk("col_b_h", b_h, 9);
        b_req = 1'b0;

        // reset mid-cooldown, with a pending B grant discarded
        a_req = 1'b1; a_dir = 2'b00;
        step(1);
        chk("rmc_a_ack", a_ack, 1);
        a_req = 1'b0;
        rst = 1'b1; b_req = 1'b1; b_dir = 2'b00;
        step(1);
        chk("rmc_a_h", a_h, 0);
        chk("rmc_a_v", a_v, 0);
        chk("rmc_a_ready", a_ready, 1);
        chk("rmc_pulses", {a_ack, a_nack, b_ack, b_nack}, 4'b0000);
        chk("rmc_b_h", b_h, 9);
        rst = 1'b0; b_req = 1'b0;

        // tie-break returns to A after reset
        a_req = 1'b1; b_req = 1'b1; a_dir = 2'b01; b_dir = 2'b00;
        step(1);
        chk("prio_rst_a_first", {a_ack, b_ack}, 2'b10);
        a_req = 1'b0;
        step(1);
        chk("prio_rst_b_next", b_ack, 1);
        b_req = 1'b0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
